hex_parser: RTL

HEX_PARSER -- requirements
Module: hex_parser

---
 rtl/hex_parser_if.sv | 27 ++
 rtl/hex_parser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hex_parser_if.sv
// hex_parser_if: byte-FIFO read side and parsed-value output side of hex_parser.
// master = parser, slave = FIFO/consumer side.
interface hex_parser_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned MAX_DIGITS = WIDTH / 4;
    localparam int unsigned DIGIT_W    = $clog2(MAX_DIGITS + 1);

    logic               data_available;
    logic [7:0]         read_data;
    logic               read_strobe;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_value;
    logic [DIGIT_W-1:0] out_digits;
    logic               error;

    modport master (
        input  data_available, read_data, out_ready,
        output read_strobe, out_valid, out_value, out_digits, error
    );

    modport slave (
        output data_available, read_data, out_ready,
        input  read_strobe, out_valid, out_value, out_digits, error
    );
endinterface

// File: rtl/hex_parser.sv
// hex_parser: turns delimiter-separated ASCII hex tokens from a byte FIFO into WIDTH-bit values.
// Define HEX_PARSER_PREFIX_EN to accept a leading "0x"/"0X" on a token.
module hex_parser #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    hex_parser_if.master bus
);
    localparam int unsigned MAX_DIGITS = WIDTH / 4;
    localparam int unsigned DIGIT_W    = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [DIGIT_W-1:0] count_q, count_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;

    logic [7:0] rd_byte;
    logic       consume;
    logic       is_dec, is_lower, is_upper, is_digit, is_delim;
    logic [3:0] nibble;

`ifdef HEX_PARSER_PREFIX_EN
    logic prefix_q, prefix_d;
    logic is_x;
`endif

    assign rd_byte = bus.read_data;

    // Pop whenever a byte is present, except while a value waits for the consumer.
    assign bus.read_strobe = reset_n & bus.data_available & (state_q != EMIT);
    assign consume         = bus.read_strobe;

    // Byte classification and hex digit decode.
    always_comb begin
        is_dec   = (rd_byte >= 8'h30) && (rd_byte <= 8'h39);
        is_lower = (rd_byte >= 8'h61) && (rd_byte <= 8'h66);
        is_upper = (rd_byte >= 8'h41) && (rd_byte <= 8'h46);
        is_digit = is_dec | is_lower | is_upper;
        is_delim = (rd_byte == 8'h20) || (rd_byte == 8'h0D) ||
                   (rd_byte == 8'h0A) || (rd_byte == 8'h2C);
        nibble   = 4'h0;
        if (is_dec) begin
            nibble = 4'(rd_byte - 8'h30);
        end else if (is_lower) begin
            nibble = 4'(rd_byte - 8'h57);
        end else if (is_upper) begin
            nibble = 4'(rd_byte - 8'h37);
        end
    end

`ifdef HEX_PARSER_PREFIX_EN
    assign is_x = (rd_byte == 8'h78) || (rd_byte == 8'h58);
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        error_d = 1'b0;
`ifdef HEX_PARSER_PREFIX_EN
        prefix_d = prefix_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (consume && !is_delim) begin
                    if (is_digit) begin
                        acc_d   = WIDTH'(nibble);
                        count_d = DIGIT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        error_d = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            ACCUM: begin
                if (consume) begin
                    if (is_digit) begin
                        if (count_q < DIGIT_W'(MAX_DIGITS)) begin
                            acc_d   = {acc_q[WIDTH-5:0], nibble};
                            count_d = count_q + DIGIT_W'(1);
                        end else begin
                            error_d = 1'b1;
                            state_d = SKIP;
                        end
`ifdef HEX_PARSER_PREFIX_EN
                    end else if (is_x && (count_q == DIGIT_W'(1)) && (acc_q == '0)) begin
                        count_d  = '0;
                        prefix_d = 1'b1;
`endif
                    end else if (is_delim) begin
`ifdef HEX_PARSER_PREFIX_EN
                        // A bare "0x" with no digits is a malformed token.
                        if (count_q == '0) begin
                            error_d = 1'b1;
                            acc_d   = '0;
                            state_d = IDLE;
                        end else
`endif
                        state_d = EMIT;
                    end else begin
                        error_d = 1'b1;
                        state_d = SKIP;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            SKIP: begin
                if (consume && is_delim) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
`ifdef HEX_PARSER_PREFIX_EN
        if (state_d != ACCUM) begin
            prefix_d = 1'b0;
        end
`endif
        valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

`ifdef HEX_PARSER_PREFIX_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prefix_q <= 1'b0;
        end else begin
            prefix_q <= prefix_d;
        end
    end
`endif

    assign bus.out_valid  = valid_q;
    assign bus.out_value  = acc_q;
    assign bus.out_digits = count_q;
    assign bus.error      = error_q;
endmodule
